// File: rtl/ysyx_icache_ifu_pkg.sv
// Shared types and helpers for the ysyx instruction fetch unit and its cache array.
// The cache itself is compiled in only when YSYX_ICACHE_EN is defined.
package ysyx_icache_ifu_pkg;

  localparam int unsigned IFU_STATE_W = 2;

  // Fetch FSM states
  typedef enum logic [IFU_STATE_W-1:0] {
    IFU_IDLE   = 2'd0,
    IFU_LOOKUP = 2'd1,
    IFU_REFILL = 2'd2,
    IFU_OUT    = 2'd3
  } ifu_state_e;

  // Index width for n entries, never narrower than one bit
  function automatic int unsigned field_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ysyx_icache_array.sv
// Direct-mapped instruction cache storage: data RAM, tag RAM and valid vector.
// Combinational read, one word written per cycle, separate line-validate and flush.
// Only instantiated when YSYX_ICACHE_EN is defined.
module ysyx_icache_array
  import ysyx_icache_ifu_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TAG_W      = 22,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SET_NUM    = 16,
  localparam int unsigned OFF_IW    = field_w(LINE_WORDS),
  localparam int unsigned IDX_W     = field_w(SET_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [OFF_IW-1:0] rd_off_i,
  output logic [DATA_W-1:0] rd_word_c_o,
  output logic [TAG_W-1:0]  rd_tag_c_o,
  output logic              rd_valid_c_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [OFF_IW-1:0] wr_off_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              line_set_i,
  input  logic [TAG_W-1:0]  line_tag_i
);

  logic [DATA_W-1:0]  data_q [SET_NUM][LINE_WORDS];
  logic [TAG_W-1:0]   tag_q  [SET_NUM];
  logic [SET_NUM-1:0] valid_q;

  assign rd_word_c_o  = data_q[rd_idx_i][rd_off_i];
  assign rd_tag_c_o   = tag_q[rd_idx_i];
  assign rd_valid_c_o = valid_q[rd_idx_i];

  // Data and tag RAMs carry no reset; the valid vector guards them
  always_ff @(posedge clk) begin
    if (wr_en_i) data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    if (line_set_i) tag_q[wr_idx_i] <= line_tag_i;
  end

  // Valid bits: reset and flush clear everything, flush wins over a validate
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (line_set_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_icache_ifu.sv
// Instruction fetch unit: accepts a PC, looks it up in a direct-mapped L1 I-cache,
// refills whole lines word by word from the bus on a miss, and hands the
// instruction to IDU. Define YSYX_ICACHE_EN to build the cache; without it every
// fetch is a single uncached bus read and flush_i is ignored.
module ysyx_icache_ifu
  import ysyx_icache_ifu_pkg::*;
#(
  parameter int unsigned      ADDR_W     = 32,
  parameter int unsigned      DATA_W     = 32,
  parameter int unsigned      LINE_WORDS = 4,
  parameter int unsigned      SET_NUM    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_valid,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] pc,
  output logic              valid_o,
  input  logic              next_ready,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] ifu_araddr_o,
  output logic              ifu_arvalid_o,
  input  logic [DATA_W-1:0] ifu_rdata,
  input  logic              ifu_rvalid
);

  localparam int unsigned WORD_BYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(WORD_BYTES - 1);

  ifu_state_e        state_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              ready_q;
  logic              valid_q;
  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc_q;

`ifdef YSYX_ICACHE_EN
  localparam int unsigned BYTE_OFF_W = $clog2(WORD_BYTES);
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS);
  localparam int unsigned OFF_IW     = field_w(LINE_WORDS);
  localparam int unsigned IDX_W      = field_w(SET_NUM);
  localparam int unsigned TAG_W      = ADDR_W - BYTE_OFF_W - OFF_W - IDX_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * WORD_BYTES - 1);
  localparam logic [OFF_IW-1:0] LAST_WORD = OFF_IW'(LINE_WORDS - 1);

  logic [OFF_IW-1:0] k_q;
  logic              gap_q;
  logic              flush_pend_q;

  logic [OFF_IW-1:0] req_off_c;
  logic [IDX_W-1:0]  req_idx_c;
  logic [TAG_W-1:0]  req_tag_c;
  logic [ADDR_W-1:0] line_base_c;
  logic [DATA_W-1:0] rd_word_c;
  logic [TAG_W-1:0]  rd_tag_c;
  logic              rd_valid_c;
  logic              hit_c;
  logic              wr_en_c;
  logic              line_set_c;

  // Address split of the latched request
  assign req_off_c   = OFF_IW'((req_pc_q >> BYTE_OFF_W) & ADDR_W'(LINE_WORDS - 1));
  assign req_idx_c   = IDX_W'(req_pc_q >> (BYTE_OFF_W + OFF_W));
  assign req_tag_c   = TAG_W'(req_pc_q >> (BYTE_OFF_W + OFF_W + IDX_W));
  assign line_base_c = req_pc_q & LINE_MASK;

  assign hit_c      = rd_valid_c && (rd_tag_c == req_tag_c);
  assign wr_en_c    = (state_q == IFU_REFILL) && !gap_q && arvalid_q && ifu_rvalid;
  // A flush seen anywhere during the refill leaves the new line invalid
  assign line_set_c = (state_q == IFU_REFILL) && gap_q && (k_q == LAST_WORD) &&
                      !flush_pend_q && !flush_i;

  ysyx_icache_array #(
    .DATA_W    (DATA_W),
    .TAG_W     (TAG_W),
    .LINE_WORDS(LINE_WORDS),
    .SET_NUM   (SET_NUM)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .rd_idx_i    (req_idx_c),
    .rd_off_i    (req_off_c),
    .rd_word_c_o (rd_word_c),
    .rd_tag_c_o  (rd_tag_c),
    .rd_valid_c_o(rd_valid_c),
    .wr_en_i     (wr_en_c),
    .wr_idx_i    (req_idx_c),
    .wr_off_i    (k_q),
    .wr_data_i   (ifu_rdata),
    .line_set_i  (line_set_c),
    .line_tag_i  (req_tag_c)
  );

  // Remember a flush that arrives while a refill is in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      flush_pend_q <= 1'b0;
    end else if (state_q != IFU_REFILL) begin
      flush_pend_q <= 1'b0;
    end else if (flush_i) begin
      flush_pend_q <= 1'b1;
    end
  end
`else
  logic unused_c;
  assign unused_c = ^{flush_i, 32'(SET_NUM * LINE_WORDS)};
`endif

  // Fetch FSM with registered handshake and bus outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IFU_IDLE;
      req_pc_q  <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      inst_q    <= '0;
      pc_q      <= RESET_PC;
`ifdef YSYX_ICACHE_EN
      k_q       <= '0;
      gap_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IFU_IDLE: begin
          if (prev_valid) begin
            req_pc_q <= pc;
            ready_q  <= 1'b0;
            state_q  <= IFU_LOOKUP;
          end
        end
        IFU_LOOKUP: begin
`ifdef YSYX_ICACHE_EN
          if (hit_c) begin
            inst_q  <= rd_word_c;
            pc_q    <= req_pc_q;
            valid_q <= 1'b1;
            state_q <= IFU_OUT;
          end else begin
            k_q       <= '0;
            gap_q     <= 1'b0;
            arvalid_q <= 1'b1;
            araddr_q  <= line_base_c;
            state_q   <= IFU_REFILL;
          end
`else
          arvalid_q <= 1'b1;
          araddr_q  <= req_pc_q & WORD_MASK;
          state_q   <= IFU_REFILL;
`endif
        end
        IFU_REFILL: begin
`ifdef YSYX_ICACHE_EN
          // Each word: request until data, then one idle cycle before the next
          if (gap_q) begin
            gap_q <= 1'b0;
            if (k_q == LAST_WORD) begin
              pc_q    <= req_pc_q;
              valid_q <= 1'b1;
              state_q <= IFU_OUT;
            end else begin
              k_q       <= k_q + 1'b1;
              arvalid_q <= 1'b1;
              araddr_q  <= line_base_c + (ADDR_W'(k_q + 1'b1) << BYTE_OFF_W);
            end
          end else if (arvalid_q && ifu_rvalid) begin
            if (k_q == req_off_c) inst_q <= ifu_rdata;
            arvalid_q <= 1'b0;
            gap_q     <= 1'b1;
          end
`else
          if (arvalid_q && ifu_rvalid) begin
            inst_q    <= ifu_rdata;
            pc_q      <= req_pc_q;
            arvalid_q <= 1'b0;
            valid_q   <= 1'b1;
            state_q   <= IFU_OUT;
          end
`endif
        end
        IFU_OUT: begin
          if (next_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IFU_IDLE;
          end
        end
        default: state_q <= IFU_IDLE;
      endcase
    end
  end

  assign ready_o       = ready_q;
  assign valid_o       = valid_q;
  assign inst_o        = inst_q;
  assign pc_o          = pc_q;
  assign ifu_arvalid_o = arvalid_q;
  assign ifu_araddr_o  = araddr_q;

endmodule

// File: tb/tb_ysyx_icache_ifu.sv
// Directed bench for ysyx_icache_ifu with a transaction-level cache model.
// Expectations follow YSYX_ICACHE_EN the same way the design does.
module tb_ysyx_icache_ifu;

`ifdef YSYX_ICACHE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        prev_valid;
  logic        ready_o;
  logic [31:0] pc;
  logic        valid_o;
  logic        next_ready;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        flush_i;
  logic [31:0] ifu_araddr_o;
  logic        ifu_arvalid_o;
  logic [31:0] ifu_rdata;
  logic        ifu_rvalid;

  ysyx_icache_ifu dut (
    .clk          (clk),
    .rst          (rst),
    .prev_valid   (prev_valid),
    .ready_o      (ready_o),
    .pc           (pc),
    .valid_o      (valid_o),
    .next_ready   (next_ready),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .flush_i      (flush_i),
    .ifu_araddr_o (ifu_araddr_o),
    .ifu_arvalid_o(ifu_arvalid_o),
    .ifu_rdata    (ifu_rdata),
    .ifu_rvalid   (ifu_rvalid)
  );

  initial forever #5 clk = ~clk;

  int          vecs = 0;
  int          errs = 0;
  int          bus_lat = 1;
  int          inj_req = 0;
  int          inj_done = 0;
  int          rsp_cnt = 0;
  bit          out_ok = 1'b0;
  bit          arv_seen = 1'b0;
  logic [31:0] exp_inst = '0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_rd[$];
  bit          mvalid[16];
  logic [31:0] mtag[16];
  int          last_lat = 0;
  logic [31:0] last_inst = '0;

  // Backing memory: a fixed table for the first line, an address hash elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a & 32'hFFFF_FFFC)
      32'h8000_0000: return 32'h11;
      32'h8000_0004: return 32'h22;
      32'h8000_0008: return 32'h33;
      32'h8000_000C: return 32'h44;
      default:       return (a & 32'hFFFF_FFFC) ^ 32'hC0DE_0000;
    endcase
  endfunction

  // Bus slave: answers after bus_lat cycles of ifu_arvalid_o, or injects a stray beat
  initial begin
    ifu_rvalid = 1'b0;
    ifu_rdata  = '0;
    forever begin
      @(negedge clk);
      ifu_rvalid = 1'b0;
      if (inj_req != inj_done) begin
        inj_done   = inj_req;
        ifu_rvalid = 1'b1;
        ifu_rdata  = 32'hDEAD_BEEF;
        rsp_cnt    = 0;
      end else if (ifu_arvalid_o && rst) begin
        rsp_cnt++;
        if (rsp_cnt >= bus_lat) begin
          ifu_rvalid = 1'b1;
          ifu_rdata  = mem_word(ifu_araddr_o);
          rsp_cnt    = 0;
        end
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  // One cycle: advance to the falling edge and check outputs against the model
  task automatic tick();
    @(negedge clk);
    if (valid_o) begin
      if (!out_ok) begin
        check("spurious_valid_o", 32'(valid_o), 32'd0);
      end else begin
        check("inst_o", inst_o, exp_inst);
        check("pc_o", pc_o, exp_pc);
      end
    end
    if (ifu_arvalid_o && !arv_seen) begin
      check("read_expected", 32'(exp_rd.size() > 0), 32'd1);
      if (exp_rd.size() > 0) check("ifu_araddr_o", ifu_araddr_o, exp_rd.pop_front());
    end
    arv_seen = ifu_arvalid_o;
  endtask

  // Fetch one PC; fmode 1 = flush at refill word 1, fmode 2 = flush during lookup
  task automatic fetch(input logic [31:0] a, input int lat, input int hold, input int fmode);
    int          n;
    int          idx;
    int          exp_lat;
    logic [31:0] tag;
    logic [31:0] base;
    bit          hit;
    bit          fl_done;
    base = a & ~32'hF;
    idx  = int'((a >> 4) & 32'hF);
    tag  = a >> 8;
    hit  = EN && mvalid[idx] && (mtag[idx] == tag);
    exp_inst = mem_word(a);
    exp_pc   = a;
    if (!hit) begin
      if (EN) for (int k = 0; k < 4; k++) exp_rd.push_back(base + 32'(4 * k));
      else exp_rd.push_back(a & ~32'h3);
    end
    exp_lat = hit ? 2 : (EN ? 2 + 4 * (lat + 1) : 2 + lat);
    bus_lat    = lat;
    pc         = a;
    prev_valid = 1'b1;
    out_ok     = 1'b1;
    check("ready_o_at_accept", 32'(ready_o), 32'd1);
    n = 0;
    fl_done = 1'b0;
    do begin
      tick();
      n++;
      flush_i = 1'b0;
      if (n == 1) begin
        prev_valid = 1'b0;
        if (fmode == 2) flush_i = 1'b1;
      end
      if (fmode == 1 && !fl_done && ifu_arvalid_o && ifu_araddr_o == base + 32'd4) begin
        flush_i = 1'b1;
        fl_done = 1'b1;
      end
    end while (!valid_o && n < 300);
    flush_i = 1'b0;
    check("latency", 32'(n), 32'(exp_lat));
    last_lat  = n;
    last_inst = inst_o;
    if (EN) begin
      if (fmode == 2) clear_model();
      if (!hit) begin
        if (fmode == 1) clear_model();
        else begin
          mvalid[idx] = 1'b1;
          mtag[idx]   = tag;
        end
      end
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("valid_o_held", 32'(valid_o), 32'd1);
    end
    next_ready = 1'b1;
    tick();
    next_ready = 1'b0;
    check("valid_o_after_take", 32'(valid_o), 32'd0);
    check("ready_o_after_take", 32'(ready_o), 32'd1);
    check("reads_consumed", 32'(exp_rd.size()), 32'd0);
    out_ok = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    prev_valid = 1'b0;
    pc         = '0;
    next_ready = 1'b0;
    flush_i    = 1'b0;
    clear_model();
    for (int i = 0; i < 16; i++) mtag[i] = '0;

    // Reset
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_ready_o", 32'(ready_o), 32'd1);
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_arvalid", 32'(ifu_arvalid_o), 32'd0);
    check("rst_araddr", ifu_araddr_o, 32'd0);
    check("rst_inst_o", inst_o, 32'd0);
    check("rst_pc_o", pc_o, 32'h8000_0000);

    // Cold miss, then a hit in the same line
    fetch(32'h8000_0008, 2, 0, 0);
    check("pin_cold_inst", last_inst, 32'h33);
    check("pin_cold_lat", 32'(last_lat), EN ? 32'd14 : 32'd4);
    fetch(32'h8000_000C, 2, 0, 0);
    check("pin_sameline_inst", last_inst, 32'h44);
    check("pin_sameline_lat", 32'(last_lat), EN ? 32'd2 : 32'd4);

    // Conflict at the same index evicts the first line
    fetch(32'h8000_0100, 1, 0, 0);
    check("pin_conflict_inst", last_inst, 32'h40DE_0100);
    fetch(32'h8000_0000, 1, 0, 0);
    check("pin_evicted_lat", 32'(last_lat), EN ? 32'd10 : 32'd3);

    // Flush in LOOKUP still honours the hit, then everything misses
    fetch(32'h8000_0004, 1, 0, 2);
    check("pin_lookup_flush_lat", 32'(last_lat), EN ? 32'd2 : 32'd3);
    check("pin_lookup_flush_inst", last_inst, 32'h22);
    fetch(32'h8000_0004, 1, 0, 0);
    check("pin_after_flush_lat", 32'(last_lat), EN ? 32'd10 : 32'd3);

    // Flush during refill: delivered but not cached
    fetch(32'h8000_0204, 2, 0, 1);
    fetch(32'h8000_0204, 2, 0, 0);
    check("pin_refill_flush_lat", 32'(last_lat), EN ? 32'd14 : 32'd4);

    // Backpressure on a hit
    fetch(32'h8000_0208, 1, 5, 0);
    check("pin_bp_inst", last_inst, 32'h40DE_0208);

    // Reset in the middle of a refill, followed by a stray read beat
    exp_rd.push_back(32'h8000_0300);
    bus_lat    = 3;
    pc         = 32'h8000_0300;
    prev_valid = 1'b1;
    tick();
    prev_valid = 1'b0;
    tick();
    check("refill_arvalid", 32'(ifu_arvalid_o), 32'd1);
    rst = 1'b0;
    tick();
    check("midrst_arvalid", 32'(ifu_arvalid_o), 32'd0);
    check("midrst_valid_o", 32'(valid_o), 32'd0);
    check("midrst_ready_o", 32'(ready_o), 32'd1);
    check("midrst_pc_o", pc_o, 32'h8000_0000);
    rst = 1'b1;
    clear_model();
    inj_req++;
    repeat (4) begin
      tick();
      check("late_rvalid_arvalid", 32'(ifu_arvalid_o), 32'd0);
      check("late_rvalid_ready_o", 32'(ready_o), 32'd1);
    end
    check("midrst_reads", 32'(exp_rd.size()), 32'd0);

    // Reset cleared the valid bits
    fetch(32'h8000_0208, 1, 0, 0);
    check("pin_postrst_lat", 32'(last_lat), EN ? 32'd10 : 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
